// File: rtl/disto16x16_ctrl.sv
// Macroblock distortion sequencer: walks the sixteen 4x4 sub-blocks of a
// latched 16x16 source/prediction pair through an external transform pair
// and accumulates |sum_b - sum_a| >> SHIFT into a 32-bit distortion value.
//
// state | meaning
// IDLE  | waiting for start; disto holds the last result
// ISSUE | one-cycle issue of the current sub-block (tt_start high)
// WAIT  | waiting for tt_done from the transform pair
module disto16x16_ctrl #(
  parameter int SHIFT = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2047:0] src,
  input  logic [2047:0] pred,
  input  logic [255:0]  w,
  output logic          tt_start,
  output logic [127:0]  tt_in_a,
  output logic [127:0]  tt_in_b,
  output logic [255:0]  tt_w,
  input  logic [31:0]   tt_sum_a,
  input  logic [31:0]   tt_sum_b,
  input  logic          tt_done,
  output logic [31:0]   disto,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state_q, state_d;
  logic [2047:0]  src_q, pred_q;
  logic [255:0]   w_q;
  logic [3:0]     blk;
  logic [31:0]    acc;
  logic           accept, blk_done;
  logic signed [32:0] diff;
  logic [32:0]    mag;
  logic [31:0]    d;

  assign accept   = start && (state_q == IDLE);
  assign blk_done = tt_done && (state_q == WAIT);
  assign tt_start = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign tt_w     = w_q;

  // Sign-extend both sums so the difference cannot wrap; the magnitude of the
  // worst case is 2^32-1, so negating a negative diff never overflows.
  always_comb begin
    diff = $signed({tt_sum_b[31], tt_sum_b}) - $signed({tt_sum_a[31], tt_sum_a});
    mag  = diff[32] ? 33'(-diff) : 33'(diff);
    d    = 32'(mag >> SHIFT);
  end

  // Next-state logic for the issue/wait loop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (tt_done) state_d = (blk == 4'd15) ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Input latches, block counter, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      pred_q <= '0;
      w_q    <= '0;
      blk    <= '0;
      acc    <= '0;
      disto  <= '0;
      done   <= 1'b0;
    end else begin
      done <= blk_done && (blk == 4'd15);
      if (accept) begin
        src_q  <= src;
        pred_q <= pred;
        w_q    <= w;
        blk    <= '0;
        acc    <= '0;
      end else if (blk_done) begin
        blk <= blk + 4'd1;
        acc <= acc + d;
        if (blk == 4'd15) disto <= acc + d;
      end
    end
  end

  // Gather the current 4x4 sub-block; blk only moves on tt_done so these
  // stay stable from ISSUE through WAIT.
  always_comb begin
    int by, bx, idx;
    tt_in_a = '0;
    tt_in_b = '0;
    by = int'(blk[3:2]);
    bx = int'(blk[1:0]);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        idx = 16 * (4 * by + r) + 4 * bx + c;
        tt_in_a[8*(4*r+c) +: 8] = src_q[8*idx +: 8];
        tt_in_b[8*(4*r+c) +: 8] = pred_q[8*idx +: 8];
      end
    end
  end

endmodule

// File: tb/tb_disto16x16_ctrl.sv
// Directed bench for disto16x16_ctrl with a 2-cycle transform-pair model.
module tb_disto16x16_ctrl;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [2047:0] src = '0;
  logic [2047:0] pred = '0;
  logic [255:0]  w = '0;
  logic          tt_start;
  logic [127:0]  tt_in_a, tt_in_b;
  logic [255:0]  tt_w;
  logic [31:0]   tt_sum_a, tt_sum_b;
  logic          tt_done = 1'b0;
  logic [31:0]   disto;
  logic          done, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  logic          p1 = 1'b0;
  bit            forced = 1'b0;
  logic [31:0]   fa = '0, fb = '0;
  logic [255:0]  w_ref;

  disto16x16_ctrl #(.SHIFT(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .pred(pred), .w(w),
    .tt_start(tt_start), .tt_in_a(tt_in_a), .tt_in_b(tt_in_b), .tt_w(tt_w),
    .tt_sum_a(tt_sum_a), .tt_sum_b(tt_sum_b), .tt_done(tt_done),
    .disto(disto), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transform pair model: tt_done two cycles after tt_start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1      <= 1'b0;
      tt_done <= 1'b0;
    end else begin
      p1      <= tt_start;
      tt_done <= p1;
    end
  end

  function automatic logic [31:0] wsum(input logic [127:0] v, input logic [255:0] ww);
    int s = 0;
    for (int j = 0; j < 16; j++) begin
      int a = int'($signed(ww[16*j +: 16]));
      int b = int'(v[8*j +: 8]);
      s += a * b;
    end
    return 32'(s);
  endfunction

  assign tt_sum_a = forced ? fa : wsum(tt_in_a, tt_w);
  assign tt_sum_b = forced ? fb : wsum(tt_in_b, tt_w);

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_frame(output logic [2047:0] f);
    for (int i = 0; i < 64; i++) f[32*i +: 32] = $urandom;
  endtask

  task automatic launch();
    start = 1'b1;
    s_cyc = cyc;
    w_ref = w;
  endtask

  // Follows one run from the cycle after start; returns in the done cycle.
  task automatic track(input logic [31:0] exp, input bit spurious, input bit idx_chk,
                       input bit scramble, input int rst_at);
    int n = 0;
    int rel;
    bit got = 0;
    logic [127:0] ev;
    logic [2047:0] junk;
    for (int t = 0; t < 80 && !got; t++) begin
      @(negedge clk);
      rel = cyc - s_cyc;
      start = spurious && (rel == 10 || rel == 20);
      if (scramble && rel == 1) begin
        rand_frame(junk); src = junk;
        rand_frame(junk); pred = junk;
        w = {8{$urandom}};
      end
      if (rel == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tt_start", tt_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_disto", disto, 0);
        chk("rst_tt_in_a", tt_in_a, 0);
        chk("rst_tt_w", tt_w, 0);
        return;
      end
      chk($sformatf("busy_rel%0d", rel), busy, (rel >= 1 && rel <= 48));
      if (tt_start) begin
        chk("tt_start_cyc", rel, 1 + 3 * n);
        chk("tt_w_latched", tt_w, w_ref);
        if (idx_chk) begin
          for (int j = 0; j < 16; j++) ev[8*j +: 8] = 8'(16 * n + j);
          chk($sformatf("tt_in_a_blk%0d", n), tt_in_a, ev);
          chk($sformatf("tt_in_b_blk%0d", n), tt_in_b, ev);
        end
        n++;
      end
      if (done) begin
        got = 1;
        chk("done_cyc", rel, 49);
        chk("disto", disto, exp);
        chk("n_tt_start", n, 16);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [2047:0] f;
    int ndone;

    #2 rst_n = 1'b0;
    #1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_disto", disto, 0);
    chk("init_tt_start", tt_start, 0);
    chk("init_tt_w", tt_w, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Run A: src == pred, behavioural sums; inputs scrambled after acceptance.
    rand_frame(f); src = f; pred = f;
    w = {8{$urandom}};
    forced = 0;
    launch();
    track(32'd0, 0, 0, 1, -1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("disto_held", disto, 0);

    // Run B: indexed pixel pattern, forced sums 1000/0.
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        f[8*(16*y+x) +: 8] = 8'(16 * ((y >> 2) * 4 + (x >> 2)) + 4 * (y & 3) + (x & 3));
    src = f; pred = f;
    forced = 1; fa = 32'd1000; fb = 32'd0;
    launch();
    track(32'd496, 0, 1, 0, -1);

    // Run C: started in the done cycle of run B.
    fa = -32'sd64; fb = 32'd64;
    launch();
    track(32'd64, 0, 0, 0, -1);
    @(negedge clk);

    // Run D: extreme sums, spurious starts while busy.
    fa = 32'h7FFF_FFFF; fb = 32'h8000_0000;
    launch();
    track(32'd2147483632, 1, 0, 0, -1);
    @(negedge clk);

    // Run E: reset mid-run, then a fresh run.
    fa = 32'd1000; fb = 32'd0;
    launch();
    track(32'd0, 0, 0, 0, 25);
    ndone = 0;
    repeat (3) begin @(negedge clk); if (done) ndone++; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    chk("no_done_after_rst", ndone, 0);
    chk("idle_after_rst", busy, 0);
    launch();
    track(32'd496, 0, 0, 0, -1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disto16x16_ctrl.md
DISTO16X16_CTRL -- requirements
Module: disto16x16_ctrl

Interface
- REQ-001: Parameter SHIFT, default 5, right-shift applied to each per-sub-block absolute difference.
- REQ-002: clk  input  1  single clock; all state changes on its rising edge.
- REQ-003: rst_n  input  1  reset; asynchronous assert, active-low.
- REQ-004: start  input  1  one-cycle request; accepted only when busy=0.
- REQ-005: src  input  2048  16x16 source macroblock, 8-bit unsigned pixels; pixel (y,x) at bits [8*(16y+x)+7 : 8*(16y+x)].
- REQ-006: pred  input  2048  16x16 prediction, same packing as src.
- REQ-007: w  input  256  sixteen 16-bit signed spectral weights.
- REQ-008: tt_start  output  1  one-cycle issue pulse to the transform pair.
- REQ-009: tt_in_a  output  128  current 4x4 source sub-block; byte j=4r+c at bits [8j+7:8j].
- REQ-010: tt_in_b  output  128  current 4x4 prediction sub-block, same packing.
- REQ-011: tt_w  output  256  latched copy of w.
- REQ-012: tt_sum_a  input  32  signed weighted sum for tt_in_a.
- REQ-013: tt_sum_b  input  32  signed weighted sum for tt_in_b.
- REQ-014: tt_done  input  1  both sums valid; arrives exactly 2 cycles after tt_start.
- REQ-015: disto  output  32  unsigned macroblock distortion, held until next done.
- REQ-016: done  output  1  one-cycle pulse; disto valid in that cycle.
- REQ-017: busy  output  1  high from the cycle after start acceptance until done is high.

Function
- REQ-018: States IDLE, ISSUE, WAIT; IDLE->ISSUE on accepted start; ISSUE->WAIT unconditionally; WAIT->ISSUE on tt_done if blk<15; WAIT->IDLE on tt_done if blk=15.
- REQ-019: On start acceptance, src, pred, w are latched; later input changes do not affect the run.
- REQ-020: 4-bit counter blk is cleared at acceptance and incremented on each tt_done in WAIT; sub-block by=blk[3:2], bx=blk[1:0].
- REQ-021: tt_in_a byte 4r+c = latched src pixel (4by+r, 4bx+c); tt_in_b likewise from pred; both are stable from ISSUE through WAIT.
- REQ-022: tt_start is high only in ISSUE, for exactly one cycle per sub-block; 16 pulses per run.
- REQ-023: Per sub-block, d = |tt_sum_b - tt_sum_a| >> SHIFT, difference computed in 33-bit signed, absolute value unsigned, logical shift.
- REQ-024: 32-bit accumulator cleared at acceptance; acc += d on each tt_done in WAIT; overflow impossible (max 16*(2^33-1)>>5 < 2^32).
- REQ-025: On the 16th tt_done, disto <= acc+d and done <= 1 registered; done is high the following cycle only.
- REQ-026: Timing: start high in cycle S -> ISSUE of block k in cycle S+1+3k -> done high in cycle S+49.
- REQ-027: start while busy=1 is ignored; start in the done cycle is accepted (busy=0 there).
- REQ-028: tt_done outside WAIT is ignored; ISSUE waits in WAIT indefinitely if tt_done is late.

Reset
- REQ-029: rst_n low asynchronously forces IDLE, blk=0, acc=0, disto=0, done=0, busy=0, tt_start=0, tt_in_a/tt_in_b/tt_w latches=0.
- REQ-030: Reset mid-run abandons the run; no done pulse; next start begins a fresh run from blk=0.

Verification
- REQ-031: Behavioural 2-cycle transform model, src=pred=random -> 16 tt_start pulses at S+1+3k, disto=0, done at S+49, busy high S+1..S+48.
- REQ-032: Model forces sum_a=1000, sum_b=0 every block -> d=31 each, disto=496.
- REQ-033: Model forces sum_a=-64, sum_b=64 -> d=4 each, disto=64; sum_a=0x7FFFFFFF, sum_b=0x80000000 -> d=134217727, disto=2147483632.
- REQ-034: src pixel (y,x)=16*((y>>2)*4+(x>>2))+ (4*(y&3)+(x&3)) -> tt_in_a byte j at block k equals 16k+j for all k, j.
- REQ-035: start pulsed at S+10 and S+20 during a run -> ignored, single done at S+49; start in done cycle -> second run done 49 cycles later.
- REQ-036: rst_n low at S+25 -> all outputs 0 immediately, no done; restart -> correct disto.
